// File: rtl/div_unit_pkg.sv
// Shared encodings for the multi-cycle DIV/DIVU unit in EX.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_abs_neg.sv
// Conditional two's-complement negate: used to take |operand| at accept time.
module div_unit_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);

    assign y = neg ? (~a + 1'b1) : a;

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring divider for MIPS DIV/DIVU; one quotient bit per cycle,
// stalling IF/ID/EX until the result is ready.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             annul,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ready,
    output logic             stallreq_for_ex
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] dsor_q, dsor_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH-1:0] dvd_abs, dsr_abs;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] rem_nx, quot_nx;

    div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_dvd (
        .a   (dividend),
        .neg (signed_div & dividend[WIDTH-1]),
        .y   (dvd_abs)
    );

    div_unit_abs_neg #(.WIDTH(WIDTH)) u_abs_dsr (
        .a   (divisor),
        .neg (signed_div & divisor[WIDTH-1]),
        .y   (dsr_abs)
    );

    // One restoring step: shift in the next dividend bit, keep the trial if it did not borrow.
    always_comb begin
        rem_sh  = {rem_q, quot_q[WIDTH-1]};
        trial   = rem_sh - {1'b0, dsor_q};
        rem_nx  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nx = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        dsor_d      = dsor_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        case (state_q)
            DIV_FREE: begin
                if (start && !annul) begin
                    neg_quot_d = signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d  = signed_div & dividend[WIDTH-1];
                    if (divisor == '0) begin
                        state_d = DIV_BYZERO;
                    end else begin
                        state_d = DIV_ON;
                        rem_d   = '0;
                        quot_d  = dvd_abs;
                        dsor_d  = dsr_abs;
                        cnt_d   = '0;
                    end
                end
            end
            DIV_ON: begin
                rem_d  = rem_nx;
                quot_d = quot_nx;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d     = DIV_END;
                    quotient_d  = neg_quot_q ? (~quot_nx + 1'b1) : quot_nx;
                    remainder_d = neg_rem_q ? (~rem_nx + 1'b1) : rem_nx;
                end
            end
            DIV_BYZERO: begin
                state_d     = DIV_END;
                quotient_d  = '0;
                remainder_d = '0;
            end
            DIV_END: begin
                if (!start) state_d = DIV_FREE;
            end
            default: state_d = DIV_FREE;
        endcase
        if (annul) state_d = DIV_FREE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= DIV_FREE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            dsor_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            dsor_q      <= dsor_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign ready           = (state_q == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign quotient        = quotient_q;
    assign remainder       = remainder_q;
    // Held low during reset so every output reads zero while rst is high.
    assign stallreq_for_ex = start & ~ready & ~annul & ~rst;

endmodule

// File: tb/tb_div_unit.sv
// Directed and random DIV/DIVU operations checked against an arithmetic reference model.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_div;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         annul;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         ready;
    logic         stallreq_for_ex;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .signed_div      (signed_div),
        .dividend        (dividend),
        .divisor         (divisor),
        .annul           (annul),
        .quotient        (quotient),
        .remainder       (remainder),
        .ready           (ready),
        .stallreq_for_ex (stallreq_for_ex)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncating division, remainder follows dividend sign; /0 gives zeros.
    function automatic void model(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            q = '0;
            r = '0;
        end else if (sd) begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Entered just after a rising edge; that cycle is cycle 0 of the op.
    task automatic run_op(input logic sd, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input string tag);
        logic [W-1:0] eq, er;
        int lat, got;
        model(sd, a, b, eq, er);
        lat = (b == '0) ? 2 : W + 1;
        got = -1;
        signed_div = sd; dividend = a; divisor = b; start = 1'b1;
        for (int c = 0; c < 100 && got < 0; c++) begin
            @(negedge clk);
            if (ready) begin
                got = c;
                check({tag, "_stall_at_ready"}, W'(stallreq_for_ex), '0);
            end else begin
                if (c == 0 || c == lat - 1) check({tag, "_stall"}, W'(stallreq_for_ex), 1);
                @(posedge clk); #1;
                if (c == 0) begin
                    signed_div = $urandom; dividend = $urandom; divisor = $urandom;
                end
            end
        end
        check({tag, "_latency"}, W'(got), W'(lat));
        check({tag, "_quot"}, quotient, eq);
        check({tag, "_rem"}, remainder, er);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check({tag, "_hold_ready"}, W'(ready), 1);
            check({tag, "_hold_quot"}, quotient, eq);
            check({tag, "_hold_rem"}, remainder, er);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ready_drop"}, W'(ready), '0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        rst = 1'b1; start = 1'b0; signed_div = 1'b0; dividend = '0; divisor = '0; annul = 1'b0;
        #12;
        check("rst_quot", quotient, '0);
        check("rst_rem", remainder, '0);
        check("rst_ready", W'(ready), '0);
        check("rst_stall", W'(stallreq_for_ex), '0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(1'b0, 32'd100, 32'd7, 0, "u100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 0, "s_m7_2");
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 0, "u_m7_2");
        run_op(1'b0, 32'd12345, 32'd0, 0, "u_div0");
        run_op(1'b1, 32'h8000_0001, 32'd0, 0, "s_div0");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, "s_ovf");
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "u_max");
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, 0, "s_7_m2");

        // Kill an op in cycle 10, then start a fresh 9/3 in cycle 12.
        signed_div = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall", W'(stallreq_for_ex), '0);
        check("annul_ready", W'(ready), '0);
        @(posedge clk); #1;
        annul = 1'b0; start = 1'b0;
        @(negedge clk);
        check("annul_after_ready", W'(ready), '0);
        @(posedge clk); #1;
        run_op(1'b0, 32'd9, 32'd3, 0, "post_annul");

        // Async reset in cycle 20 of an op, after a nonzero result is held.
        run_op(1'b0, 32'd77, 32'd5, 0, "pre_rst");
        signed_div = 1'b0; dividend = 32'd50000; divisor = 32'd7; start = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("arst_quot", quotient, '0);
        check("arst_rem", remainder, '0);
        check("arst_ready", W'(ready), '0);
        check("arst_stall", W'(stallreq_for_ex), '0);
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, 3, "post_rst_hold");

        for (int i = 0; i < 24; i++) begin
            rs = 1'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = W'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run_op(rs, ra, rb, 0, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
